// File: rtl/btn_pkg.sv
// Shared types and elaboration helpers for the push-button conditioning blocks.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned sys_clk,
                                               input int unsigned ms);
    return sys_clk / 1000 * ms;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clkout,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Synchronise, debounce and classify an active-low push-button into a clean level
// plus single-cycle press / release / short-click / long-press strobes.
//
//   state   | meaning
//   IDLE    | debounced level released, waiting for a press
//   PRESSED | pressed, hold time below the long-press threshold
//   HELD    | long press already reported, waiting for release
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned SYS_CLK     = 100000000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic CLK,
  input  logic RESETBTN,
  input  logic BTN_N,
  output logic LEVEL,
  output logic PRESS,
  output logic RELEASE,
  output logic SHORT,
  output logic LONG
);

  localparam int unsigned DB_CYCLES   = ms_to_cycles(SYS_CLK, DEBOUNCE_MS);
  localparam int unsigned LONG_CYCLES = ms_to_cycles(SYS_CLK, LONG_MS);
  localparam int unsigned DB_W        = cnt_width(DB_CYCLES);
  localparam int unsigned HOLD_W      = cnt_width(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              btn_sync;
  logic              pressed_s;
  logic [DB_W-1:0]   db_cnt;
  logic              db_done;
  logic              rise_evt;
  logic              fall_evt;

  btn_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              press_d, release_d, short_d, long_d;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clkout (CLK),
    .rst_n  (RESETBTN),
    .d      (BTN_N),
    .q      (btn_sync)
  );

  assign pressed_s = ~btn_sync;

  // The FSM reacts to the toggle decision itself so its strobes line up
  // with the edge on which LEVEL changes.
  assign db_done  = (pressed_s != LEVEL) && (db_cnt == DB_LAST);
  assign rise_evt = db_done && !LEVEL;
  assign fall_evt = db_done && LEVEL;

  always_ff @(posedge CLK or negedge RESETBTN) begin
    if (!RESETBTN) begin
      db_cnt <= '0;
      LEVEL  <= 1'b0;
    end else if (pressed_s == LEVEL) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      LEVEL  <= ~LEVEL;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETBTN) begin
    if (!RESETBTN) begin
      state_q <= IDLE;
      hold_q  <= '0;
      PRESS   <= 1'b0;
      RELEASE <= 1'b0;
      SHORT   <= 1'b0;
      LONG    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      PRESS   <= press_d;
      RELEASE <= release_d;
      SHORT   <= short_d;
      LONG    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_evt) begin
          state_d = PRESSED;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        // Release takes priority over reaching the long threshold on the same edge.
        if (fall_evt) begin
          state_d   = IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = HELD;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      HELD: begin
        if (fall_evt) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Front-end conditioner for the board push-buttons. It synchronises a raw, bouncing, active-low button into the `CLK` domain and debounces it into a clean level. It emits single-cycle press, release, short-click and long-press strobes. It sits directly upstream of the LED/blink logic, which consumes the clean level and strobes in place of raw button pins.

## Interface
- `SYS_CLK`, default 100000000: `CLK` frequency in Hz.
- `DEBOUNCE_MS`, default 10: required stable time in ms. `DB_CYCLES = SYS_CLK/1000*DEBOUNCE_MS`, must be ≥1.
- `LONG_MS`, default 1000: hold time for a long press, measured from the debounced press. `LONG_CYCLES = SYS_CLK/1000*LONG_MS`, must be ≥1.
- `CLK` input, 1 bit: system clock; all flops on its rising edge.
- `RESETBTN` input, 1 bit: asynchronous, active-low reset (assert async, release sync to `CLK` upstream).
- `BTN_N` input, 1 bit: raw button, asynchronous, low = pressed.
- `LEVEL` output, 1 bit: debounced state, 1 = pressed.
- `PRESS` output, 1 bit: 1-cycle strobe on `LEVEL` 0→1.
- `RELEASE` output, 1 bit: 1-cycle strobe on `LEVEL` 1→0.
- `SHORT` output, 1 bit: 1-cycle strobe on release before the long threshold is reached.
- `LONG` output, 1 bit: 1-cycle strobe when the hold reaches `LONG_CYCLES`; at most once per press.

## Operation
- **Synchroniser:** 2-FF chain on `BTN_N`, reset to 1 (released). `pressed_s = ~sync2`.
- **Debounce counter** `db_cnt`, width `$clog2(DB_CYCLES)` (min 1):
  - Each edge, if `pressed_s == LEVEL`: `db_cnt <= 0`.
  - Else, if `db_cnt == DB_CYCLES-1`: `LEVEL <= ~LEVEL`, `db_cnt <= 0`.
  - Else: `db_cnt++`.
  - Any agreeing sample restarts the count. A bounce shorter than `DB_CYCLES` consecutive samples never reaches `LEVEL`.
- **FSM** `IDLE` / `PRESSED` / `HELD`, reset `IDLE`:
  - `IDLE` → `PRESSED` on `LEVEL` rising. Assert `PRESS`, clear `hold_cnt`.
  - `PRESSED`: `hold_cnt++` each cycle.
    - At `hold_cnt == LONG_CYCLES-1`: assert `LONG`, go to `HELD`.
    - On `LEVEL` falling: assert `RELEASE` and `SHORT`, go to `IDLE`.
    - If both occur on the same edge, release wins: `RELEASE` + `SHORT`, no `LONG`.
  - `HELD`: `hold_cnt` frozen. On `LEVEL` falling: assert `RELEASE` only, go to `IDLE`.
- `hold_cnt` width is `$clog2(LONG_CYCLES)` (min 1) and never wraps; it is cleared on entry to `PRESSED`.
- All strobes are registered and high for exactly one cycle. `PRESS` and `RELEASE` are never high together.
- **Reset values:** `LEVEL`, `PRESS`, `RELEASE`, `SHORT`, `LONG` = 0; `db_cnt` = `hold_cnt` = 0; state `IDLE`; sync flops = 1.
- **Reset mid-operation:** on `RESETBTN` low, outputs clear asynchronously and no strobe is produced. A button still held after reset release is treated as a new press with full debounce latency.

## Timing
- Let `BTN_N` go low before edge k and stay low. Then:
  - `sync1` captures at edge k, `sync2` at k+1.
  - `LEVEL` rises at edge k+1+`DB_CYCLES`.
  - `PRESS` is high in the cycle after that same edge.
- Release has the same latency: `LEVEL` falls at k'+1+`DB_CYCLES`, with `RELEASE` (and `SHORT` if applicable) on that edge.
- With `LEVEL` rising at edge e, `LONG` asserts at edge e+`LONG_CYCLES`, provided `LEVEL` is still 1 throughout.
- `DB_CYCLES=1`: `LEVEL` rises at k+2.

## Structure
- Package `btn_pkg` holds:
  - the state typedef (`IDLE`=2'd0, `PRESSED`=2'd1, `HELD`=2'd2);
  - function `ms_to_cycles(sys_clk, ms)`;
  - constant helper for counter width (min 1).
- One sub-module: `sync_2ff`, a reset-to-value two-flop synchroniser with parameter `RST_VAL`. It is reused by other async inputs.
- Debounce counter and FSM stay in `btn_debounce`.

## Test plan
All scenarios use `SYS_CLK=100000`, `DEBOUNCE_MS=1`, `LONG_MS=5`, giving `DB_CYCLES=100` and `LONG_CYCLES=500`.
- **Reset:** `RESETBTN=0`, `BTN_N=1` → all outputs 0. Release reset, idle 50 cycles → all outputs stay 0.
- **Bounce rejection:** `BTN_N` toggles every 30 cycles for 300 cycles, then held at 1 → `LEVEL` stays 0, no strobes.
- **Pulse-width threshold:**
  - 99-cycle low pulse → nothing.
  - 100-cycle low pulse → `LEVEL` rises at k+101 with `PRESS`; the following release gives `RELEASE` + `SHORT` at k'+101.
- **Short click:** low at edge k, held 300 cycles → `PRESS` at k+101. Release → `RELEASE` and `SHORT` same cycle, `LONG` never asserts.
- **Long press:** low held 1000 cycles, `LEVEL` rises at e → exactly one `LONG` at e+500. Release → `RELEASE` only, `SHORT` = 0.
- **Reset while `HELD`:** `RESETBTN` pulled low → outputs 0 immediately. Release reset with `BTN_N` still low → `LEVEL`/`PRESS` at edge 101 after the first post-reset edge.
